// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Constants and the entry layout shared between fetch, the gshare predictor and
// the branch update queue. An in-flight branch entry is packed as
// {pc, history, prediction}, with prediction in bit 0.
// Ports: none (package).
// -----------------------------------------------------------------------------
package branch_pkg;

   localparam int PC_WIDTH            = 16;
   localparam int DEFAULT_HISTORY_LEN = 8;
   localparam int ENTRY_WIDTH         = PC_WIDTH + DEFAULT_HISTORY_LEN + 1;

   // Entry layout at the default history length.
   typedef struct packed {
      logic [PC_WIDTH-1:0]            pc;
      logic [DEFAULT_HISTORY_LEN-1:0] history;
      logic                           prediction;
   } branch_entry_t;

   // Packed entry width for a non-default history length.
   function automatic int entry_width(input int history_len);
      return PC_WIDTH + history_len + 1;
   endfunction

endpackage

// File: rtl/branch_entry_fifo.sv
// -----------------------------------------------------------------------------
// branch_entry_fifo
// Circular storage for in-flight branch entries: head (oldest) and tail
// pointers wrap modulo DEPTH, an occupancy counter separates full from empty.
// flush_younger pops the head and discards every entry behind it in one edge.
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   push_en        write push_data at tail (caller guarantees !full, !flush)
//   push_data      packed entry
//   pop_en         remove head entry (caller guarantees !empty)
//   flush_younger  pop head and drop all younger entries (count -> 0)
//   head_data      entry at head
//   count          occupancy
//   full, empty    occupancy flags
// -----------------------------------------------------------------------------
module branch_entry_fifo
   import branch_pkg::*;
#(
   parameter int WIDTH = ENTRY_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_en,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop_en,
   input  logic                     flush_younger,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] head_ptr;
   logic [PTR_W-1:0] tail_ptr;
   logic [CNT_W-1:0] count_next;

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign head_data = mem[head_ptr];

   // NOTE: every variable assigned in always_comb gets a default first so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      count_next = count;
      if (flush_younger)
         count_next = '0;
      else if (push_en && !pop_en)
         count_next = count + CNT_W'(1);
      else if (pop_en && !push_en)
         count_next = count - CNT_W'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else begin
         count <= count_next;
         if (pop_en || flush_younger)
            head_ptr <= head_ptr + PTR_W'(1);
         // After a flush the queue is empty, so tail meets the new head.
         if (flush_younger)
            tail_ptr <= head_ptr + PTR_W'(1);
         else if (push_en)
            tail_ptr <= tail_ptr + PTR_W'(1);
      end
   end

   // NOTE: the storage array has no reset; an entry is only read after it has
   // been written, and the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push_en)
         mem[tail_ptr] <= push_data;
   end

endmodule

// File: rtl/branch_update_queue.sv
// -----------------------------------------------------------------------------
// branch_update_queue
// In-order buffer between fetch and execute. Holds {pc, history, prediction}
// for each in-flight branch; on resolution drives the gshare write port with
// the fetch-time history, pulses mispredict and flushes wrong-path entries.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   push_valid / push_ready         fetch handshake (push_ready = !full)
//   push_pc, push_history,
//   push_prediction                 entry captured at prediction time
//   resolve_valid, resolve_taken    execute resolves the oldest branch
//   pc_bits_write, history_write,
//   outcome, write_enabled          registered predictor update port
//   mispredict                      registered one-cycle redirect pulse
//   resolve_error                   registered pulse: resolve while empty
//   count                           occupancy
//   stat_resolved, stat_mispredicted  saturating counters, only when
//                                   BRANCH_UPDATE_QUEUE_STATS_EN is defined
// -----------------------------------------------------------------------------
module branch_update_queue
   import branch_pkg::*;
#(
   parameter int HISTORY_LEN = DEFAULT_HISTORY_LEN,
   parameter int DEPTH       = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push_valid,
   output logic                   push_ready,
   input  logic [PC_WIDTH-1:0]    push_pc,
   input  logic [HISTORY_LEN-1:0] push_history,
   input  logic                   push_prediction,
   input  logic                   resolve_valid,
   input  logic                   resolve_taken,
   output logic [PC_WIDTH-1:0]    pc_bits_write,
   output logic [HISTORY_LEN-1:0] history_write,
   output logic                   outcome,
   output logic                   write_enabled,
   output logic                   mispredict,
   output logic                   resolve_error,
   output logic [$clog2(DEPTH):0] count
`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
   ,
   output logic [15:0]            stat_resolved,
   output logic [15:0]            stat_mispredicted
`endif
);

   localparam int ENTRY_W = entry_width(HISTORY_LEN);

   logic [ENTRY_W-1:0]     head_data;
   logic                   full;
   logic                   empty;
   logic                   pop;
   logic                   wrong_path;
   logic                   push_take;
   logic [PC_WIDTH-1:0]    head_pc;
   logic [HISTORY_LEN-1:0] head_history;
   logic                   head_prediction;

   assign head_pc         = head_data[ENTRY_W-1 -: PC_WIDTH];
   assign head_history    = head_data[HISTORY_LEN:1];
   assign head_prediction = head_data[0];

   assign push_ready = !full;
   assign pop        = resolve_valid && !empty;
   assign wrong_path = pop && (resolve_taken != head_prediction);
   // A push alongside a mispredicting resolve is on the wrong path.
   assign push_take  = push_valid && push_ready && !wrong_path;

   branch_entry_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk           (clk),
      .reset         (reset),
      .push_en       (push_take),
      .push_data     ({push_pc, push_history, push_prediction}),
      .pop_en        (pop),
      .flush_younger (wrong_path),
      .head_data     (head_data),
      .count         (count),
      .full          (full),
      .empty         (empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         write_enabled <= 1'b0;
         mispredict    <= 1'b0;
         resolve_error <= 1'b0;
         pc_bits_write <= '0;
         history_write <= '0;
         outcome       <= 1'b0;
      end else begin
         write_enabled <= pop;
         mispredict    <= wrong_path;
         resolve_error <= resolve_valid && empty;
         // Update payload holds between strobes; only write_enabled qualifies it.
         if (pop) begin
            pc_bits_write <= head_pc;
            history_write <= head_history;
            outcome       <= resolve_taken;
         end
      end
   end

`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_resolved     <= '0;
         stat_mispredicted <= '0;
      end else begin
         if (write_enabled && (stat_resolved != 16'hFFFF))
            stat_resolved <= stat_resolved + 16'd1;
         if (mispredict && (stat_mispredicted != 16'hFFFF))
            stat_mispredicted <= stat_mispredicted + 16'd1;
      end
   end
`endif

endmodule

// File: doc/branch_update_queue.md
# branch_update_queue

In-order buffer between fetch and execute that holds the PC, gshare history snapshot and prediction of every in-flight branch until execute resolves it. On resolution it drives the gshare predictor's write port (`pc_bits_write`, `history_write`, `outcome`, `write_enabled`) with the original fetch-time history. It also raises a mispredict redirect and flushes the younger wrong-path entries.

## Interface
- `HISTORY_LEN`, 8, width of the history snapshot; must match the predictor.
- `DEPTH`, 4, number of in-flight branch entries; power of two, 2..16.

- `clk` input, 1 bit: rising-edge clock.
- `reset` input, 1 bit: synchronous, active-high; clears the queue and all registered outputs.
- `push_valid` input, 1 bit: fetch has a predicted branch this cycle.
- `push_ready` output, 1 bit: queue not full; combinational, equals `!full`.
- `push_pc` input, 16 bits: branch PC.
- `push_history` input, HISTORY_LEN bits: predictor `history_read_out` at prediction time.
- `push_prediction` input, 1 bit: predictor `prediction` (1 = taken).
- `resolve_valid` input, 1 bit: execute resolves the oldest branch.
- `resolve_taken` input, 1 bit: actual outcome.
- `pc_bits_write` output, 16 bits: to predictor.
- `history_write` output, HISTORY_LEN bits: to predictor.
- `outcome` output, 1 bit: to predictor.
- `write_enabled` output, 1 bit: one-cycle update strobe to predictor.
- `mispredict` output, 1 bit: one-cycle pulse; prediction differed from outcome.
- `resolve_error` output, 1 bit: one-cycle pulse; resolve arrived while empty.
- `count` output, $clog2(DEPTH)+1 bits: current occupancy.

## Operation
- Circular buffer with head (oldest) and tail pointers of $clog2(DEPTH) bits, which wrap modulo DEPTH. An occupancy counter distinguishes full from empty.
- Push is accepted when `push_valid && push_ready`. The entry {pc, history, prediction} is written at the tail and tail increments.
- Resolve with the queue non-empty:
  - Head entry is popped.
  - Next cycle: `write_enabled`=1, `pc_bits_write`=entry pc, `history_write`=entry history, `outcome`=`resolve_taken`.
  - `mispredict`=1 if `resolve_taken` != entry prediction.
- Mispredict flush:
  - At the same edge as the pop, every younger entry is discarded: tail := head+1, count := 0.
  - A push presented in that same cycle is wrong-path and is dropped, even if `push_ready` is high.
- Resolve with the queue empty: nothing popped, no predictor write, `resolve_error` pulses next cycle.
- Push and correct resolve in the same cycle: both take effect and count is unchanged.
  - When full, `push_ready` is 0, so the push is not taken even though a slot frees this cycle.
- Push while full: ignored; state unchanged.
- Reset:
  - count=0, head=tail=0.
  - `write_enabled`, `mispredict` and `resolve_error` are 0.
  - `pc_bits_write`, `history_write` and `outcome` are 0.
  - Reset in mid-operation discards all entries; no update is emitted for them.
- Stored entry contents are not reset; only the pointers are.

## Timing
- Push to entry visible at head: 1 cycle.
- Resolve to `write_enabled`/`mispredict`: 1 cycle; all predictor-side outputs are registered.
- `push_ready` and `count` reflect state after the last edge.
- `push_ready` is combinational from count only; there is no path from `push_valid` to `push_ready`.
- Each strobe is high for exactly one cycle per resolve; back-to-back resolves give back-to-back strobes.

## Configuration
- `BRANCH_UPDATE_QUEUE_STATS_EN` defined:
  - Adds 16-bit saturating counters `stat_resolved` and `stat_mispredicted` as outputs, both cleared by `reset`.
  - Each increments on the cycle its strobe is high.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package `branch_pkg`:
  - Entry field widths: PC_WIDTH=16 and the default HISTORY_LEN.
  - Packed entry layout {pc, history, prediction} plus its total width.
  - These constants are shared with the predictor and fetch.
- Sub-module `branch_entry_fifo`:
  - Parameterised storage plus pointers and count.
  - Takes a `flush_younger` input.
  - Top level holds the compare, flush and registered output logic.

## Test plan
- Reset, then push pc=0x0040 hist=0x00 pred=1; resolve taken=1 → next cycle `write_enabled`=1, `pc_bits_write`=0x0040, `history_write`=0x00, `outcome`=1, `mispredict`=0.
- Push 3 entries; resolve the head with taken=0 where pred=1 → `mispredict`=1, `count`=0 after the edge, and the next resolve gives `resolve_error`=1.
- Fill to DEPTH=4 → `push_ready`=0; a 5th push is ignored; resolve all 4 in order → 4 consecutive strobes with the original PCs, pointers wrap correctly.
- Push in the same cycle as a mispredicting resolve → the push is dropped and `count`=0.
- Reset asserted with 2 entries queued and a resolve pending → no `write_enabled` follows and `count`=0.
- With `BRANCH_UPDATE_QUEUE_STATS_EN`: 5 resolves, 2 mispredicted → `stat_resolved`=5, `stat_mispredicted`=2.
